// File: rtl/cache_pkg.sv
// Shared types and helpers for the fully associative write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } cache_state_e;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_WAYS   = 4;

    // Width of a per-way age / way index; at least one bit.
    function automatic int unsigned age_w(input int unsigned ways);
        return (ways < 2) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_lru_age.sv
// True-LRU age tracker: ages form a permutation of 0..WAYS-1, the oldest way is the victim.
module cache_lru_age
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = DEF_WAYS,
    parameter int unsigned AGE_W = age_w(WAYS)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             touch_i,
    input  logic [AGE_W-1:0] touch_idx_i,
    output logic [AGE_W-1:0] lru_idx_o
);

    logic [AGE_W-1:0] age_q [WAYS];
    logic [AGE_W-1:0] age_d [WAYS];
    logic [AGE_W-1:0] old_age;

    // Touched way becomes youngest; every way younger than its old age ages by one.
    always_comb begin
        old_age = age_q[touch_idx_i];
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_i) begin
                if (AGE_W'(i) == touch_idx_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < old_age) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        for (int i = 0; i < WAYS; i++) begin
            if (reset_i) begin
                age_q[i] <= AGE_W'(i);
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end

    always_comb begin
        lru_idx_o = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == AGE_W'(WAYS - 1)) begin
                lru_idx_o = AGE_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_fa_wb.sv
// Fully associative write-back/write-allocate cache, one word per line, true-LRU.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_fa_wb
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WAYS   = DEF_WAYS
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_hit_o,
    output logic              mem_valid_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef CACHE_STATS_EN
    output logic [15:0]       hit_count_o,
    output logic [15:0]       miss_count_o,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam int unsigned AGE_W = age_w(WAYS);

    // Valid/ready: a transfer happens on a posedge where both valid and ready are high;
    // a requester holds its payload stable from raising valid until that edge.
    cache_state_e state_q, state_d;

    logic [ADDR_W-1:0] tag_q  [WAYS];
    logic [DATA_W-1:0] data_q [WAYS];
    logic [WAYS-1:0]   valid_q, dirty_q;

    logic              req_write_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [AGE_W-1:0]  victim_q, victim_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              hit_any, inv_any;
    logic [AGE_W-1:0]  hit_idx, inv_idx, lru_idx, victim_sel;

    logic              wr_en, wr_dirty, touch;
    logic [AGE_W-1:0]  wr_idx, touch_idx;
    logic [ADDR_W-1:0] wr_tag;
    logic [DATA_W-1:0] wr_data;

    cache_lru_age #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .touch_i     (touch),
        .touch_idx_i (touch_idx),
        .lru_idx_o   (lru_idx)
    );

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_addr_i)) begin
                hit_any = 1'b1;
                hit_idx = AGE_W'(i);
            end
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = AGE_W'(i);
            end
        end
        victim_sel = inv_any ? inv_idx : lru_idx;
    end

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        hit_d     = hit_q;
        rdata_d   = rdata_q;
        wr_en     = 1'b0;
        wr_idx    = victim_q;
        wr_tag    = req_addr_q;
        wr_data   = req_wdata_q;
        wr_dirty  = 1'b1;
        touch     = 1'b0;
        touch_idx = victim_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    hit_d = hit_any;
                    if (hit_any) begin
                        touch     = 1'b1;
                        touch_idx = hit_idx;
                        if (req_write_i) begin
                            wr_en   = 1'b1;
                            wr_idx  = hit_idx;
                            wr_tag  = req_addr_i;
                            wr_data = req_wdata_i;
                        end else begin
                            rdata_d = data_q[hit_idx];
                        end
                        state_d = S_RESP;
                    end else begin
                        victim_d = victim_sel;
                        if (valid_q[victim_sel] && dirty_q[victim_sel]) begin
                            state_d = S_WB;
                        end else if (!req_write_i) begin
                            state_d = S_FILL;
                        end else begin
                            wr_en     = 1'b1;
                            wr_idx    = victim_sel;
                            wr_tag    = req_addr_i;
                            wr_data   = req_wdata_i;
                            touch     = 1'b1;
                            touch_idx = victim_sel;
                            state_d   = S_RESP;
                        end
                    end
                end
            end
            S_WB: begin
                if (mem_ready_i) begin
                    if (req_write_q) begin
                        wr_en   = 1'b1;
                        touch   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (mem_ready_i) begin
                    wr_en    = 1'b1;
                    wr_data  = mem_rdata_i;
                    wr_dirty = 1'b0;
                    rdata_d  = mem_rdata_i;
                    touch    = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            hit_q    <= hit_d;
            rdata_q  <= rdata_d;
            if (state_q == S_IDLE && req_valid_i) begin
                req_write_q <= req_write_i;
                req_addr_q  <= req_addr_i;
                req_wdata_q <= req_wdata_i;
            end
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= wr_dirty;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en && !reset_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_hit_o   = (state_q == S_RESP) && hit_q;
    assign resp_rdata_o = rdata_q;
    assign mem_valid_o  = (state_q == S_WB) || (state_q == S_FILL);
    assign mem_write_o  = (state_q == S_WB);
    assign mem_addr_o   = (state_q == S_WB)   ? tag_q[victim_q] :
                          (state_q == S_FILL) ? req_addr_q : '0;
    assign mem_wdata_o  = (state_q == S_WB)   ? data_q[victim_q] : '0;
    assign dbg_state_o  = state_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (hit_q && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit_q && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fa_wb.sv
// Randomised bench for cache_fa_wb against a recency-list cache model and a backing-RAM model.
module tb_cache_fa_wb;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int WAYS   = 4;
    localparam int MW     = 1 + ADDR_W + DATA_W;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_write, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic resp_valid, resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic mem_valid, mem_write, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0] dbg_state;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_fa_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_hit_o   (resp_hit),
        .mem_valid_o  (mem_valid),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_ready_i  (mem_ready),
        .mem_rdata_i  (mem_rdata),
`ifdef CACHE_STATS_EN
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
`endif
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Backing RAM and expected memory transactions {write, addr, wdata-or-0}.
    logic [DATA_W-1:0] mem_arr [256];
    logic [MW-1:0] exp_q[$];
    int force_lat = -1;
    int wb_cnt = 0;
    logic [ADDR_W-1:0] last_wb_addr;
    logic [DATA_W-1:0] last_wb_data;

    // Cache model: index 0 is most recently used.
    logic [ADDR_W-1:0] m_addr[$];
    logic [DATA_W-1:0] m_data[$];
    bit m_dirty[$];
    logic [DATA_W-1:0] exp_rd;

    task automatic model_clear();
        m_addr.delete();
        m_data.delete();
        m_dirty.delete();
        exp_q.delete();
        exp_rd = '0;
    endtask

    task automatic model_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                output bit hit, output logic [DATA_W-1:0] rd);
        int f;
        logic [DATA_W-1:0] ld;
        bit dd;
        f = -1;
        rd = '0;
        for (int i = 0; i < m_addr.size(); i++) if (m_addr[i] == a) f = i;
        if (f >= 0) begin
            hit = 1'b1;
            ld = m_data[f];
            dd = m_dirty[f];
            if (wr) begin
                ld = d;
                dd = 1'b1;
            end
            rd = ld;
            m_addr.delete(f);
            m_data.delete(f);
            m_dirty.delete(f);
            m_addr.push_front(a);
            m_data.push_front(ld);
            m_dirty.push_front(dd);
        end else begin
            hit = 1'b0;
            if (m_addr.size() == WAYS) begin
                if (m_dirty[$]) exp_q.push_back({1'b1, m_addr[$], m_data[$]});
                void'(m_addr.pop_back());
                void'(m_data.pop_back());
                void'(m_dirty.pop_back());
            end
            if (wr) begin
                m_addr.push_front(a);
                m_data.push_front(d);
                m_dirty.push_front(1'b1);
            end else begin
                exp_q.push_back({1'b0, a, {DATA_W{1'b0}}});
                rd = mem_arr[a];
                m_addr.push_front(a);
                m_data.push_front(rd);
                m_dirty.push_front(1'b0);
            end
        end
    endtask

    // Memory responder: checks each transaction, holds it for a random or forced wait.
    initial begin
        bit busy;
        int wait_n;
        logic [ADDR_W-1:0] h_addr;
        logic [DATA_W-1:0] h_wdata;
        logic h_write;
        busy = 1'b0;
        wait_n = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!mem_valid) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_n = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                    h_addr = mem_addr;
                    h_wdata = mem_wdata;
                    h_write = mem_write;
                    if (exp_q.size() == 0) begin
                        check_eq("mem_txn_expected", 32'(exp_q.size()), 1);
                    end else begin
                        check_eq("mem_txn", {mem_write, mem_addr, mem_write ? mem_wdata : {DATA_W{1'b0}}},
                                 exp_q.pop_front());
                    end
                    if (mem_write) begin
                        wb_cnt++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end
                end else begin
                    check_eq("mem_addr_stable", mem_addr, h_addr);
                    check_eq("mem_wdata_stable", mem_wdata, h_wdata);
                    check_eq("mem_write_stable", mem_write, h_write);
                end
                if (wait_n == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr[mem_addr];
                    if (mem_write) mem_arr[mem_addr] = mem_wdata;
                    busy = 1'b0;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output bit hit_o, output int lat);
        bit eh, got;
        logic [DATA_W-1:0] er;
        int w;
        model_access(wr, a, d, eh, er);
        if (!wr) exp_rd = er;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_wdata = d;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
            else check_eq("req_ready_busy", req_ready, 0);
        end
        check_eq("resp_seen", got, 1);
        hit_o = 1'b0;
        if (got) begin
            hit_o = resp_hit;
            check_eq("resp_hit", resp_hit, eh);
            check_eq("resp_rdata", resp_rdata, exp_rd);
            if (eh) check_eq("hit_latency", lat, 1);
            @(negedge clk);
            check_eq("resp_pulse", resp_valid, 0);
        end
    endtask

    initial begin
        bit h, eh;
        int lat, wb0;
        logic [DATA_W-1:0] er;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rst = 1'b1;
        exp_rd = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = DATA_W'($urandom_range(0, 255));

        // Reset state
        do_reset();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_hit", resp_hit, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_mem_valid", mem_valid, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);

        // Read miss with a 2-cycle memory wait, then a hit
        mem_arr[8'h10] = 8'h5A;
        force_lat = 2;
        do_req(1'b0, 8'h10, 8'h00, h, lat);
        check_eq("s1_miss", h, 0);
        check_eq("s1_rdata", resp_rdata, 8'h5A);
        check_eq("s1_latency", lat, 4);
        force_lat = -1;
        do_req(1'b0, 8'h10, 8'h00, h, lat);
        check_eq("s1_rehit", h, 1);
        check_eq("s1_rehit_data", resp_rdata, 8'h5A);
`ifdef CACHE_STATS_EN
        check_eq("stat_hits", hit_count, 1);
        check_eq("stat_misses", miss_count, 1);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        do_req(1'b0, 8'h10, 8'h00, h, lat);
        check_eq("stat_hits_sat", hit_count, 16'hFFFF);
`endif

        // Write miss with free ways: allocate without memory traffic
        wb0 = wb_cnt;
        do_req(1'b1, 8'h20, 8'h33, h, lat);
        check_eq("s2_write_miss", h, 0);
        do_req(1'b0, 8'h20, 8'h00, h, lat);
        check_eq("s2_read_hit", h, 1);
        check_eq("s2_read_data", resp_rdata, 8'h33);
        check_eq("s2_no_wb", wb_cnt, wb0);

        // Dirty LRU eviction
        do_reset();
        for (int i = 1; i <= 4; i++) do_req(1'b1, 8'(i), 8'(8'hA0 + i), h, lat);
        do_req(1'b0, 8'h01, 8'h00, h, lat);
        wb0 = wb_cnt;
        do_req(1'b1, 8'h05, 8'hA5, h, lat);
        check_eq("s3_miss", h, 0);
        check_eq("s3_wb_count", wb_cnt, wb0 + 1);
        check_eq("s3_wb_addr", last_wb_addr, 8'h02);
        check_eq("s3_wb_data", last_wb_data, 8'hA2);
        do_req(1'b0, 8'h01, 8'h00, h, lat);
        check_eq("s3_keep_hit", h, 1);

        // Long fill stall
        do_reset();
        force_lat = 10;
        do_req(1'b0, 8'h40, 8'h00, h, lat);
        check_eq("s4_latency", lat, 12);
        force_lat = -1;

        // Reset in the middle of a fill
        do_reset();
        do_req(1'b0, 8'h10, 8'h00, h, lat);
        force_lat = 30;
        model_access(1'b0, 8'h50, 8'h00, eh, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 8'h50;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("s5_fill_active", mem_valid, 1);
        check_eq("s5_fill_addr", mem_addr, 8'h50);
        check_eq("s5_no_resp", resp_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("s5_mem_dropped", mem_valid, 0);
        check_eq("s5_req_ready", req_ready, 1);
        check_eq("s5_resp_quiet", resp_valid, 0);
        rst = 1'b0;
        model_clear();
        force_lat = -1;
        do_req(1'b0, 8'h10, 8'h00, h, lat);
        check_eq("s5_invalidated", h, 0);

        // Random traffic over a small address set to force hits and evictions
        for (int n = 0; n < 300; n++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 255)) : ADDR_W'($urandom_range(0, 11));
            do_req(1'($urandom_range(0, 1)), a, DATA_W'($urandom_range(0, 255)), h, lat);
        end
        check_eq("mem_q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
